hamming_dec_engine: RTL and testbench
=====================================

Name: hamming_dec_engine

Overview:
- Hardware downstream stage of the program-1 encoder: walks N_WORDS 16-bit Hamming(16,11) SECDED words in data memory, corrects single-bit errors, flags double-bit errors, and writes decoded 11-bit messages plus a 2-bit status back to memory.
- Sits beside dat_mem as a memory-walking accelerator, started by req and reporting completion on done, with the same top-level handshake as the processor.

Parameters:
- N_WORDS, 15, number of words processed per request (1..15).
- SRC_BASE, 30, byte address of first encoded word (low byte at SRC_BASE+2i, high byte at +2i+1).
- DST_BASE, 0, byte address of first decoded output (low at DST_BASE+2i, high at +2i+1).
- AW, 8, memory address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  start request, level, sampled only in IDLE.
- done  out  1  high while in DONE.
- mem_addr  out  AW  byte address to dat_mem.
- mem_rd_data  in  8  dat_mem read data, combinational (same-cycle) read.
- mem_wr_en  out  1  byte write strobe, written on next rising edge.
- mem_wr_data  out  8  write data.
- sec_cnt  out  4  count of corrected single errors this run, saturating at 15.
- ded_cnt  out  4  count of detected double errors this run, saturating at 15.

Behaviour:
- Reset: state=IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, sec_cnt=0, ded_cnt=0, word index i=0. Reset mid-run aborts immediately with no further writes. Bytes already written stay in memory.
- Encoded word w[15:0]={hi,lo}: bit k (1..15) is Hamming position k, and bit 0 is overall parity p0.
  - Parity positions: p1=bit1, p2=bit2, p4=bit4, p8=bit8.
  - Data positions: d1=bit3, d2..d4=bits5..7, d5..d11=bits9..15.
- syndrome[3:0] = XOR of indices k of all set bits among 1..15. par = XOR of all 16 bits.
- Classification:
  - par=0, syn=0: clean, flag=00.
  - par=1: single error at position syn (syn=0 means p0). Flip that bit, flag=01, sec_cnt++.
  - par=0, syn!=0: double error, data left uncorrected (raw bits), flag=10, ded_cnt++.
- Output bytes: hi={flag[1:0],3'b000,d11,d10,d9}, lo={d8..d1}.
- FSM: IDLE -> RD_LO -> RD_HI -> WR_LO -> WR_HI -> (RD_LO if i<N_WORDS-1, else DONE).
  - IDLE: req=1 at an edge clears counters and i, then moves to RD_LO.
  - RD_LO: mem_addr=SRC_BASE+2i; lo latched at edge.
  - RD_HI: mem_addr=SRC_BASE+2i+1; hi latched at edge.
  - WR_LO: mem_addr=DST_BASE+2i, mem_wr_en=1, data=decoded lo; counters update at this edge.
  - WR_HI: mem_addr=DST_BASE+2i+1, mem_wr_en=1, data=decoded hi; i++ at edge.
  - DONE: done=1 and counters held. req=1 restarts (done=0 next cycle, counters cleared). req=0 stays in DONE.
- Latency: 4 cycles per word. done rises 4*N_WORDS edges after the req-sampling edge (60 for default).
- req while busy is ignored. mem_wr_en is 0 in IDLE, RD_LO, RD_HI and DONE.
- Address arithmetic is AW-bit and wraps modulo 2^AW with no error.
- Counters saturate at 15 and do not wrap.

Test Plan:
- Clean word: mem[30]=0x5A, mem[31]=0xAA, N_WORDS=1 -> mem[0]=0x55, mem[1]=0x05, sec_cnt=0, ded_cnt=0, done 4 edges after req.
- Single data error (bit6 flipped): mem[30]=0x1A, mem[31]=0xAA -> mem[0]=0x55, mem[1]=0x45, sec_cnt=1.
- p0 error: mem[30]=0x5B, mem[31]=0xAA -> mem[0]=0x55, mem[1]=0x45, sec_cnt=1.
- Double error (bits 6 and 9): mem[30]=0x1A, mem[31]=0xA8 -> mem[0]=0x41, mem[1]=0x85, ded_cnt=1, sec_cnt=0.
- Full run: 15 random words, each encoded with a random 0/1/2-bit flip -> all 30 output bytes match the reference model, done after exactly 60 edges, counters equal the injected counts.
- reset asserted at edge 10 of a 15-word run -> done=0, outputs zero, mem[20..29] unchanged. A later req reruns from word 0 with counters cleared.

Source files
------------

// File: rtl/hamming_dec_engine.sv
// Memory-walking Hamming(16,11) SECDED decoder: reads N_WORDS encoded words, corrects
// single-bit errors, flags double-bit errors and writes decoded message plus status back.
module hamming_dec_engine #(
  parameter int N_WORDS  = 15,
  parameter int SRC_BASE = 30,
  parameter int DST_BASE = 0,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  output logic [3:0]    sec_cnt,
  output logic [3:0]    ded_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [3:0]    LAST_IDX = 4'(N_WORDS - 1);
  localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);

  // Returns {flag[1:0], 3'b000, d11..d9, d8..d1}; single errors are flipped back first.
  function automatic logic [15:0] secded_decode(input logic [15:0] w_in);
    logic [15:0] w;
    logic [3:0]  syn;
    logic [1:0]  flag;
    w   = w_in;
    syn = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (w[k]) syn = syn ^ 4'(k);
    end
    if (^w) begin
      w[syn] = ~w[syn];
      flag   = 2'b01;
    end else if (syn != 4'd0) begin
      flag = 2'b10;
    end else begin
      flag = 2'b00;
    end
    return {flag, 3'b000, w[15:13], w[12:9], w[7:5], w[3]};
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    i_q, i_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [3:0]    sec_q, sec_d;
  logic [3:0]    ded_q, ded_d;
  logic [15:0]   dec_s;
  logic [AW-1:0] off_s;

  assign dec_s = secded_decode({hi_q, lo_q});
  assign off_s = AW'({i_q, 1'b0});

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= 4'd0;
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
      sec_q   <= 4'd0;
      ded_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sec_q   <= sec_d;
      ded_q   <= ded_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    sec_d   = sec_q;
    ded_d   = ded_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          state_d = S_RD_LO;
          i_d     = 4'd0;
          sec_d   = 4'd0;
          ded_d   = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RD_LO: begin
        lo_d    = mem_rd_data;
        state_d = S_RD_HI;
      end
      S_RD_HI: begin
        hi_d    = mem_rd_data;
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        // Counters saturate rather than wrap.
        if (dec_s[15:14] == 2'b01 && sec_q != 4'hF) begin
          sec_d = sec_q + 4'd1;
        end else if (dec_s[15:14] == 2'b10 && ded_q != 4'hF) begin
          ded_d = ded_q + 4'd1;
        end else begin
          sec_d = sec_q;
        end
        state_d = S_WR_HI;
      end
      S_WR_HI: begin
        i_d = i_q + 4'd1;
        if (i_q < LAST_IDX) begin
          state_d = S_RD_LO;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    done        = 1'b0;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;
    case (state_q)
      S_RD_LO: mem_addr = SRC_A + off_s;
      S_RD_HI: mem_addr = SRC_A + off_s + AW'(1);
      S_WR_LO: begin
        mem_addr    = DST_A + off_s;
        mem_wr_en   = 1'b1;
        mem_wr_data = dec_s[7:0];
      end
      S_WR_HI: begin
        mem_addr    = DST_A + off_s + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = dec_s[15:8];
      end
      S_DONE:  done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  assign sec_cnt = sec_q;
  assign ded_cnt = ded_q;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Bench for hamming_dec_engine: directed single-word vectors on a 1-word instance and
// randomized 15-word runs against a position-index reference model on a 15-word instance.
module tb_hamming_dec_engine;

  logic       clk, reset;
  logic       req1, done1, we1;
  logic [7:0] addr1, rd1, wd1;
  logic [3:0] sec1, ded1;
  logic       req15, done15, we15;
  logic [7:0] addr15, rd15, wd15;
  logic [3:0] sec15, ded15;

  logic       tb_we1, tb_we15;
  logic [7:0] tb_addr, tb_data;
  logic [7:0] mem1 [256];
  logic [7:0] mem15[256];

  int total = 0;
  int bad   = 0;

  hamming_dec_engine #(.N_WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .done(done1), .mem_addr(addr1),
    .mem_rd_data(rd1), .mem_wr_en(we1), .mem_wr_data(wd1), .sec_cnt(sec1), .ded_cnt(ded1));

  hamming_dec_engine #(.N_WORDS(15)) dut15 (
    .clk(clk), .reset(reset), .req(req15), .done(done15), .mem_addr(addr15),
    .mem_rd_data(rd15), .mem_wr_en(we15), .mem_wr_data(wd15), .sec_cnt(sec15), .ded_cnt(ded15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd1  = mem1[addr1];
  assign rd15 = mem15[addr15];

  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wd1;
    else if (tb_we1) mem1[tb_addr] <= tb_data;
  end

  always @(posedge clk) begin
    if (we15) mem15[addr15] <= wd15;
    else if (tb_we15) mem15[tb_addr] <= tb_data;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference encoder: data in non-power-of-two positions, parity bits zero the syndrome.
  function automatic logic [15:0] ref_encode(input logic [10:0] m);
    logic [15:0] w;
    int j, s;
    w = 16'd0; j = 0; s = 0;
    for (int k = 1; k < 16; k++) if ((k & (k - 1)) != 0) begin w[k] = m[j]; j++; end
    for (int k = 1; k < 16; k++) if (w[k]) s = s ^ k;
    for (int p = 1; p < 16; p = p * 2) if ((s & p) != 0) w[p] = 1'b1;
    w[0] = ^w[15:1];
    return w;
  endfunction

  // Reference decoder: returns {hi_byte, lo_byte}.
  function automatic logic [15:0] ref_decode(input logic [15:0] w);
    logic [15:0] v;
    logic [10:0] d;
    logic [1:0]  f;
    int s, j;
    v = w; s = 0; j = 0; d = 11'd0;
    for (int k = 1; k < 16; k++) if (v[k]) s = s ^ k;
    if ($countones(v) % 2 == 1) begin v[s] = ~v[s]; f = 2'b01; end
    else if (s != 0) f = 2'b10;
    else f = 2'b00;
    for (int k = 1; k < 16; k++) if ((k & (k - 1)) != 0) begin d[j] = v[k]; j++; end
    return {f, 3'b000, d[10:8], d[7:0]};
  endfunction

  task automatic load(input int which, input int a, input logic [7:0] d);
    @(negedge clk);
    tb_addr = 8'(a);
    tb_data = d;
    tb_we1  = (which == 1);
    tb_we15 = (which == 15);
    @(negedge clk);
    tb_we1  = 1'b0;
    tb_we15 = 1'b0;
  endtask

  // Pulses/holds req, returns number of edges after the sampling edge until done.
  task automatic run(input int which, input int hold, output int n);
    int bound;
    bound = (which == 1) ? 30 : 80;
    @(negedge clk);
    if (which == 1) req1 = 1'b1; else req15 = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    if (hold == 0) begin req1 = 1'b0; req15 = 1'b0; end
    while (!((which == 1) ? done1 : done15) && n < bound) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n >= hold) begin req1 = 1'b0; req15 = 1'b0; end
    end
    req1 = 1'b0;
    req15 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] lo, hi, e0, e1;
    logic [3:0] es, ed;
  } vec_t;

  logic [7:0] exp_out[30];
  logic [7:0] snap[30];
  int exp_sec, exp_ded;

  task automatic gen_and_load();
    logic [15:0] w, dec;
    int nf, a, b;
    exp_sec = 0;
    exp_ded = 0;
    for (int i = 0; i < 15; i++) begin
      w  = ref_encode(11'($urandom));
      nf = int'($urandom_range(0, 2));
      a  = int'($urandom_range(0, 15));
      b  = (a + 1 + int'($urandom_range(0, 14))) % 16;
      if (nf >= 1) w[a] = ~w[a];
      if (nf == 2) w[b] = ~w[b];
      if (nf == 1) exp_sec++;
      if (nf == 2) exp_ded++;
      dec = ref_decode(w);
      exp_out[2*i]   = dec[7:0];
      exp_out[2*i+1] = dec[15:8];
      load(15, 30 + 2*i, w[7:0]);
      load(15, 31 + 2*i, w[15:8]);
    end
  endtask

  task automatic check_full(input string tag, input int n);
    chk({tag, "_edges"}, n, 60);
    chk({tag, "_done"}, int'(done15), 1);
    chk({tag, "_wren_done"}, int'(we15), 0);
    for (int b = 0; b < 30; b++) chk($sformatf("%s_byte%0d", tag, b), int'(mem15[b]), int'(exp_out[b]));
    chk({tag, "_sec"}, int'(sec15), exp_sec);
    chk({tag, "_ded"}, int'(ded15), exp_ded);
  endtask

  initial begin
    vec_t vecs[7];
    int n;
    vecs[0] = '{8'h5A, 8'hAA, 8'h55, 8'h05, 4'd0, 4'd0};
    vecs[1] = '{8'h1A, 8'hAA, 8'h55, 8'h45, 4'd1, 4'd0};
    vecs[2] = '{8'h5A, 8'hAA, 8'h55, 8'h05, 4'd0, 4'd0};
    vecs[3] = '{8'h5B, 8'hAA, 8'h55, 8'h45, 4'd1, 4'd0};
    vecs[4] = '{8'h1A, 8'hA8, 8'h41, 8'h85, 4'd0, 4'd1};
    vecs[5] = '{8'h5A, 8'hAB, 8'h55, 8'h45, 4'd1, 4'd0};
    vecs[6] = '{8'h59, 8'hAA, 8'h55, 8'h85, 4'd0, 4'd1};

    reset = 1'b1; req1 = 1'b0; req15 = 1'b0;
    tb_we1 = 1'b0; tb_we15 = 1'b0; tb_addr = 8'd0; tb_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_done", int'(done1), 0);
    chk("rst_wren", int'(we1), 0);
    chk("rst_addr", int'(addr1), 0);
    chk("rst_wdata", int'(wd1), 0);
    chk("rst_sec", int'(sec1), 0);
    chk("rst_ded", int'(ded1), 0);
    chk("rst_done15", int'(done15), 0);

    for (int i = 0; i < 7; i++) begin
      load(1, 30, vecs[i].lo);
      load(1, 31, vecs[i].hi);
      load(1, 0, 8'hEE);
      load(1, 1, 8'hEE);
      run(1, 0, n);
      chk($sformatf("v%0d_edges", i), n, 4);
      chk($sformatf("v%0d_mem0", i), int'(mem1[0]), int'(vecs[i].e0));
      chk($sformatf("v%0d_mem1", i), int'(mem1[1]), int'(vecs[i].e1));
      chk($sformatf("v%0d_sec", i), int'(sec1), int'(vecs[i].es));
      chk($sformatf("v%0d_ded", i), int'(ded1), int'(vecs[i].ed));
    end

    // Random full run with req held high into the run (must be ignored while busy).
    gen_and_load();
    run(15, 20, n);
    check_full("runA", n);
    repeat (3) @(negedge clk);
    chk("runA_done_hold", int'(done15), 1);

    // New sources, then reset sampled at edge 10 of the run.
    gen_and_load();
    for (int b = 0; b < 30; b++) snap[b] = mem15[b];
    @(negedge clk);
    req15 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req15 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_done", int'(done15), 0);
    chk("abort_wren", int'(we15), 0);
    chk("abort_addr", int'(addr15), 0);
    chk("abort_wdata", int'(wd15), 0);
    chk("abort_sec", int'(sec15), 0);
    chk("abort_ded", int'(ded15), 0);
    chk("abort_byte0", int'(mem15[0]), int'(exp_out[0]));
    chk("abort_byte3", int'(mem15[3]), int'(exp_out[3]));
    repeat (6) @(negedge clk);
    chk("abort_idle_done", int'(done15), 0);
    for (int b = 4; b < 30; b++) chk($sformatf("abort_keep%0d", b), int'(mem15[b]), int'(snap[b]));

    run(15, 0, n);
    check_full("rerun", n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
